// File: rtl/psqwd_pkg.sv
`default_nettype none
// ============================================================================
// psqwd_pkg : shared types and constants for the square-wave decoder
// Revision  : 1.0
// ============================================================================
package psqwd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_REM     = 2'b10;
    localparam logic [1:0] ERR_ZERO    = 2'b11;

    localparam int unsigned CLK_PER_UNIT_DEF = 5;

endpackage
`default_nettype wire

// File: rtl/psqwd_phase_cnt.sv
`default_nettype none
// ============================================================================
// psqwd_phase_cnt : prescaler plus unit counter measuring one phase length
// Revision        : 1.0
// ============================================================================
module psqwd_phase_cnt
    import psqwd_pkg::*;
#(
    parameter int unsigned CLK_PER_UNIT = CLK_PER_UNIT_DEF,
    parameter int unsigned UNIT_W       = 4,
    parameter int unsigned PRE_W        = $clog2(CLK_PER_UNIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    output logic [UNIT_W:0]   units_o,
    output logic [PRE_W-1:0]  pre_o,
    output logic              timeout_o
);

    localparam logic [UNIT_W:0]  UNITS_LIMIT = {1'b1, {UNIT_W{1'b0}}};
    localparam logic [PRE_W-1:0] PRE_WRAP    = PRE_W'(CLK_PER_UNIT - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [UNIT_W:0]  units_q, units_d;

    assign timeout_o = (units_q == UNITS_LIMIT);
    assign units_o   = units_q;
    assign pre_o     = pre_q;

    // Counting freezes at the timeout limit so the unit count never wraps.
    always_comb begin
        pre_d   = pre_q;
        units_d = units_q;
        if (load_i) begin
            pre_d   = PRE_W'(1);
            units_d = '0;
        end else if (en_i && !timeout_o) begin
            if (pre_q == PRE_WRAP) begin
                pre_d   = '0;
                units_d = units_q + 1'b1;
            end else begin
                pre_d   = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            units_q <= '0;
        end else begin
            pre_q   <= pre_d;
            units_q <= units_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psqwd_meas.sv
`default_nettype none
// ============================================================================
// psqwd_meas : square-wave decoder reporting high/low phase lengths in units
// Revision   : 1.0   (optional PSQWD_ROUND_EN: round phases to nearest unit)
// ============================================================================
module psqwd_meas
    import psqwd_pkg::*;
#(
    parameter int unsigned CLK_PER_UNIT = CLK_PER_UNIT_DEF,
    parameter int unsigned UNIT_W       = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sq_in,
    output logic [UNIT_W-1:0] m_out,
    output logic [UNIT_W-1:0] n_out,
    output logic              valid,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned PRE_W = $clog2(CLK_PER_UNIT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s, rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sq_in};
            prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    state_e            state_q;
    logic [UNIT_W:0]   units;
    logic [PRE_W-1:0]  pre;
    logic              timeout;
    logic              cnt_load, cnt_en;

    // Every edge that advances the FSM also restarts the phase count.
    assign cnt_load = en && (((state_q != HIGH) && rise) || ((state_q == HIGH) && fall));
    assign cnt_en   = (state_q != IDLE);

    psqwd_phase_cnt #(
        .CLK_PER_UNIT (CLK_PER_UNIT),
        .UNIT_W       (UNIT_W),
        .PRE_W        (PRE_W)
    ) u_phase_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .units_o   (units),
        .pre_o     (pre),
        .timeout_o (timeout)
    );

    logic [1:0]        cls_code;
    logic [UNIT_W-1:0] cls_val;

`ifdef PSQWD_ROUND_EN
    logic            round_up;
    logic [UNIT_W:0] rounded;

    assign round_up = ((32'(pre) << 1) >= CLK_PER_UNIT);
    assign rounded  = units + {{UNIT_W{1'b0}}, round_up};

    // A rounded value past the field width cannot be reported; flag it as too long.
    always_comb begin
        cls_code = ERR_NONE;
        cls_val  = rounded[UNIT_W-1:0];
        if (rounded == '0) begin
            cls_code = ERR_ZERO;
        end else if (rounded[UNIT_W]) begin
            cls_code = ERR_TIMEOUT;
        end
    end
`else
    always_comb begin
        cls_code = ERR_NONE;
        cls_val  = units[UNIT_W-1:0];
        if (units == '0) begin
            cls_code = ERR_ZERO;
        end else if (units[UNIT_W]) begin
            cls_code = ERR_TIMEOUT;
        end else if (pre != '0) begin
            cls_code = ERR_REM;
        end
    end
`endif

    logic [UNIT_W-1:0] m_q, n_q, mcap_q;
    logic              valid_q, err_q, pend_q;
    logic [1:0]        err_code_q, pend_code_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            mcap_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            pend_q      <= 1'b0;
            pend_code_q <= ERR_NONE;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!en) begin
                state_q     <= IDLE;
                pend_q      <= 1'b0;
                pend_code_q <= ERR_NONE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (timeout) begin
                            err_q       <= 1'b1;
                            err_code_q  <= ERR_TIMEOUT;
                            pend_q      <= 1'b0;
                            pend_code_q <= ERR_NONE;
                            state_q     <= IDLE;
                        end else if (fall) begin
                            if (cls_code == ERR_NONE) begin
                                mcap_q <= cls_val;
                            end else begin
                                pend_q      <= 1'b1;
                                pend_code_q <= cls_code;
                            end
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (timeout) begin
                            err_q       <= 1'b1;
                            err_code_q  <= ERR_TIMEOUT;
                            pend_q      <= 1'b0;
                            pend_code_q <= ERR_NONE;
                            state_q     <= IDLE;
                        end else if (rise) begin
                            // A high-phase error outranks anything found in the low phase.
                            if (pend_q) begin
                                err_q      <= 1'b1;
                                err_code_q <= pend_code_q;
                            end else if (cls_code != ERR_NONE) begin
                                err_q      <= 1'b1;
                                err_code_q <= cls_code;
                            end else begin
                                valid_q <= 1'b1;
                                m_q     <= mcap_q;
                                n_q     <= cls_val;
                            end
                            pend_q      <= 1'b0;
                            pend_code_q <= ERR_NONE;
                            state_q     <= HIGH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_out    = m_q;
    assign n_out    = n_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
`default_nettype wire
